// File: rtl/mycpu_pkg.sv
// Shared encodings for the memory-access stage: load sizes and stage FSM states.
package mycpu_pkg;

  localparam logic [1:0] LD_B = 2'd0;
  localparam logic [1:0] LD_H = 2'd1;
  localparam logic [1:0] LD_W = 2'd2;
  localparam logic [1:0] LD_D = 2'd3;

  typedef enum logic [1:0] {
    MS_EMPTY = 2'd0,
    MS_WAIT  = 2'd1,
    MS_READY = 2'd2
  } ms_state_e;

endpackage

// File: rtl/load_align.sv
// Load data alignment: picks the byte/half/word lane at the address offset and
// sign- or zero-extends it to XLEN. Purely combinational.
module load_align
  import mycpu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]            rdata,
  input  logic [$clog2(XLEN/8)-1:0]  offset,
  input  logic [1:0]                 size,
  input  logic                       ld_unsigned,
  output logic [XLEN-1:0]            result
);

  localparam int OFFW = $clog2(XLEN/8);

  logic [OFFW+2:0] shamt;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] mask;
  logic            sign_bit;

  assign shamt   = {offset, 3'b000};
  assign shifted = rdata >> shamt;

  always_comb begin
    mask     = '1;
    sign_bit = 1'b0;
    case (size)
      LD_B: begin
        mask     = XLEN'(8'hFF);
        sign_bit = shifted[7];
      end
      LD_H: begin
        mask     = XLEN'(16'hFFFF);
        sign_bit = shifted[15];
      end
      LD_W: begin
        mask     = XLEN'(32'hFFFF_FFFF);
        sign_bit = shifted[31];
      end
      default: begin
        mask     = '1;
        sign_bit = 1'b0;
      end
    endcase
  end

  // Bits above the loaded field are filled with the sign bit unless unsigned.
  assign result = (shifted & mask) | (~mask & {XLEN{sign_bit & ~ld_unsigned}});

endmodule

// File: rtl/mem_stage_pipe.sv
// Memory-access pipeline stage: holds one instruction, waits for in-order data
// responses, buffers them under write-back stall and discards responses of flushed loads.
module mem_stage_pipe
  import mycpu_pkg::*;
#(
  parameter int XLEN            = 32,
  parameter int REG_AW          = 5,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              es_to_ms_valid,
  output logic              ms_allowin,
  input  logic [XLEN-1:0]   es_pc,
  input  logic              es_gr_we,
  input  logic [REG_AW-1:0] es_dest,
  input  logic [XLEN-1:0]   es_alu_result,
  input  logic              es_res_from_mem,
  input  logic              es_mem_req,
  input  logic [1:0]        es_ld_size,
  input  logic              es_ld_unsigned,
  input  logic              data_sram_data_ok,
  input  logic [XLEN-1:0]   data_sram_rdata,
  output logic              ms_to_ws_valid,
  input  logic              ws_allowin,
  output logic [XLEN-1:0]   ms_pc,
  output logic              ms_gr_we,
  output logic [REG_AW-1:0] ms_dest,
  output logic [XLEN-1:0]   ms_final_result,
  output logic              ms_fwd_valid,
  output logic              ms_fwd_block
);

  localparam int OFFW = $clog2(XLEN/8);
  localparam int CNTW = $clog2(MAX_OUTSTANDING + 1);

  ms_state_e         state;
  ms_state_e         state_nxt;
  logic [CNTW-1:0]   discard_cnt;
  logic [CNTW-1:0]   discard_cnt_nxt;

  logic [XLEN-1:0]   ms_alu_result;
  logic              ms_res_from_mem;
  logic [1:0]        ms_ld_size;
  logic              ms_ld_unsigned;
  logic [XLEN-1:0]   rdata_buf;

  logic              ms_valid;
  logic              cnt_zero;
  logic              resp_take;
  logic              ready_go;
  logic              accept;
  logic              leave;
  logic              buf_load;
  logic              cnt_inc;
  logic              cnt_dec;
  logic [XLEN-1:0]   load_src;
  logic [XLEN-1:0]   load_data;

  assign ms_valid  = (state != MS_EMPTY);
  assign cnt_zero  = (discard_cnt == '0);
  // A response only belongs to the held load once all flushed requests are drained.
  assign resp_take = (state == MS_WAIT) && data_sram_data_ok && cnt_zero;
  assign ready_go  = (state == MS_READY) || resp_take;

  assign ms_allowin     = !ms_valid || (ready_go && ws_allowin);
  assign ms_to_ws_valid = ms_valid && ready_go;
  assign accept         = es_to_ms_valid && ms_allowin && !flush;
  assign leave          = ms_valid && ready_go && ws_allowin;
  assign buf_load       = resp_take && !ws_allowin && !flush;

  assign ms_fwd_valid = ms_valid && ms_gr_we && ready_go;
  assign ms_fwd_block = ms_valid && ms_gr_we && ms_res_from_mem && !ready_go;

  // In WAIT the response is used directly; in READY the buffered copy is used.
  assign load_src = (state == MS_WAIT) ? data_sram_rdata : rdata_buf;

  load_align #(.XLEN(XLEN)) u_load_align (
    .rdata       (load_src),
    .offset      (ms_alu_result[OFFW-1:0]),
    .size        (ms_ld_size),
    .ld_unsigned (ms_ld_unsigned),
    .result      (load_data)
  );

  assign ms_final_result = ms_res_from_mem ? load_data : ms_alu_result;

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = MS_EMPTY;
    end else if (accept) begin
      state_nxt = es_mem_req ? MS_WAIT : MS_READY;
    end else if (leave) begin
      state_nxt = MS_EMPTY;
    end else if (resp_take) begin
      state_nxt = MS_READY;
    end
  end

  // A flushed load still owes a response unless it arrives this very cycle.
  assign cnt_dec = data_sram_data_ok && !cnt_zero;
  assign cnt_inc = flush && (state == MS_WAIT) && !resp_take;

  always_comb begin
    discard_cnt_nxt = discard_cnt;
    case ({cnt_inc, cnt_dec})
      2'b10: begin
        if (discard_cnt != CNTW'(MAX_OUTSTANDING)) begin
          discard_cnt_nxt = discard_cnt + 1'b1;
        end
      end
      2'b01:   discard_cnt_nxt = discard_cnt - 1'b1;
      default: discard_cnt_nxt = discard_cnt;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= MS_EMPTY;
      discard_cnt <= '0;
    end else begin
      state       <= state_nxt;
      discard_cnt <= discard_cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ms_pc           <= '0;
      ms_gr_we        <= 1'b0;
      ms_dest         <= '0;
      ms_alu_result   <= '0;
      ms_res_from_mem <= 1'b0;
      ms_ld_size      <= 2'b00;
      ms_ld_unsigned  <= 1'b0;
    end else if (accept) begin
      ms_pc           <= es_pc;
      ms_gr_we        <= es_gr_we;
      ms_dest         <= es_dest;
      ms_alu_result   <= es_alu_result;
      ms_res_from_mem <= es_res_from_mem;
      ms_ld_size      <= es_ld_size;
      ms_ld_unsigned  <= es_ld_unsigned;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata_buf <= '0;
    end else if (buf_load) begin
      rdata_buf <= data_sram_rdata;
    end
  end

  discard_cnt_saturation: assert property (@(posedge clk) disable iff (!resetn)
    !(cnt_inc && !cnt_dec && (discard_cnt == CNTW'(MAX_OUTSTANDING))));

endmodule

// File: tb/tb_mem_stage_pipe.sv
// Directed bench for mem_stage_pipe with a retire scoreboard checked at every hand-off.
module tb_mem_stage_pipe;
  import mycpu_pkg::*;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  logic              clk = 1'b0;
  logic              resetn;
  logic              flush;
  logic              es_to_ms_valid;
  logic              ms_allowin;
  logic [XLEN-1:0]   es_pc;
  logic              es_gr_we;
  logic [REG_AW-1:0] es_dest;
  logic [XLEN-1:0]   es_alu_result;
  logic              es_res_from_mem;
  logic              es_mem_req;
  logic [1:0]        es_ld_size;
  logic              es_ld_unsigned;
  logic              data_sram_data_ok;
  logic [XLEN-1:0]   data_sram_rdata;
  logic              ms_to_ws_valid;
  logic              ws_allowin;
  logic [XLEN-1:0]   ms_pc;
  logic              ms_gr_we;
  logic [REG_AW-1:0] ms_dest;
  logic [XLEN-1:0]   ms_final_result;
  logic              ms_fwd_valid;
  logic              ms_fwd_block;

  always #5 clk = ~clk;

  mem_stage_pipe #(.XLEN(XLEN), .REG_AW(REG_AW), .MAX_OUTSTANDING(2)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .flush             (flush),
    .es_to_ms_valid    (es_to_ms_valid),
    .ms_allowin        (ms_allowin),
    .es_pc             (es_pc),
    .es_gr_we          (es_gr_we),
    .es_dest           (es_dest),
    .es_alu_result     (es_alu_result),
    .es_res_from_mem   (es_res_from_mem),
    .es_mem_req        (es_mem_req),
    .es_ld_size        (es_ld_size),
    .es_ld_unsigned    (es_ld_unsigned),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ws_allowin        (ws_allowin),
    .ms_pc             (ms_pc),
    .ms_gr_we          (ms_gr_we),
    .ms_dest           (ms_dest),
    .ms_final_result   (ms_final_result),
    .ms_fwd_valid      (ms_fwd_valid),
    .ms_fwd_block      (ms_fwd_block)
  );

  typedef struct {
    logic [XLEN-1:0]   pc;
    logic [REG_AW-1:0] dest;
    logic [XLEN-1:0]   res;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    if (ms_to_ws_valid && ws_allowin) begin
      chk("retire_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("retire_pc", 64'(ms_pc), 64'(e.pc));
        chk("retire_dest", 64'(ms_dest), 64'(e.dest));
        chk("retire_we", 64'(ms_gr_we), 64'd1);
        chk("retire_result", 64'(ms_final_result), 64'(e.res));
      end
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    #2;
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [XLEN-1:0] pc, input logic [REG_AW-1:0] dest,
                       input logic [XLEN-1:0] alu, input logic rfm, input logic req,
                       input logic [1:0] size, input logic uns);
    es_pc           = pc;
    es_gr_we        = 1'b1;
    es_dest         = dest;
    es_alu_result   = alu;
    es_res_from_mem = rfm;
    es_mem_req      = req;
    es_ld_size      = size;
    es_ld_unsigned  = uns;
    es_to_ms_valid  = 1'b1;
    #1;
    chk("offer_allowin", 64'(ms_allowin), 64'd1);
    cyc();
    es_to_ms_valid = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; flush = 1'b0; es_to_ms_valid = 1'b0; es_pc = '0; es_gr_we = 1'b0;
    es_dest = '0; es_alu_result = '0; es_res_from_mem = 1'b0; es_mem_req = 1'b0;
    es_ld_size = LD_W; es_ld_unsigned = 1'b0; data_sram_data_ok = 1'b0;
    data_sram_rdata = '0; ws_allowin = 1'b1;
    #2;
    chk("rst_allowin", 64'(ms_allowin), 64'd1);
    chk("rst_to_ws_valid", 64'(ms_to_ws_valid), 64'd0);
    chk("rst_final_result", 64'(ms_final_result), 64'd0);
    chk("rst_pc", 64'(ms_pc), 64'd0);
    chk("rst_fwd", 64'({ms_fwd_valid, ms_fwd_block}), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // ALU op: one-cycle latency
    sb.push_back('{pc: 32'h100, dest: 5'd3, res: 32'h1234_5678});
    offer(32'h100, 5'd3, 32'h1234_5678, 1'b0, 1'b0, LD_W, 1'b0);
    chk("alu_to_ws_valid", 64'(ms_to_ws_valid), 64'd1);
    chk("alu_result", 64'(ms_final_result), 64'h1234_5678);
    chk("alu_fwd_valid", 64'(ms_fwd_valid), 64'd1);
    cyc();
    chk("alu_drained", 64'(ms_to_ws_valid), 64'd0);

    // signed byte load, offset 3, response three cycles after accept
    sb.push_back('{pc: 32'h104, dest: 5'd4, res: 32'hFFFF_FF80});
    offer(32'h104, 5'd4, 32'h0000_1003, 1'b1, 1'b1, LD_B, 1'b0);
    for (int i = 0; i < 2; i++) begin
      chk("lb_wait_block", 64'(ms_fwd_block), 64'd1);
      chk("lb_wait_valid", 64'(ms_to_ws_valid), 64'd0);
      chk("lb_wait_allowin", 64'(ms_allowin), 64'd0);
      cyc();
    end
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h80FF_FF00;
    #1;
    chk("lb_comb_valid", 64'(ms_to_ws_valid), 64'd1);
    chk("lb_comb_block", 64'(ms_fwd_block), 64'd0);
    chk("lb_comb_fwd", 64'(ms_fwd_valid), 64'd1);
    cyc();
    data_sram_data_ok = 1'b0;
    #1;
    chk("lb_after_allowin", 64'(ms_allowin), 64'd1);

    // unsigned half load, offset 2, response lands during write-back stall
    sb.push_back('{pc: 32'h108, dest: 5'd5, res: 32'h0000_80FF});
    ws_allowin = 1'b0;
    offer(32'h108, 5'd5, 32'h0000_2002, 1'b1, 1'b1, LD_H, 1'b1);
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h80FF_FF00;
    #1;
    chk("lh_stall_valid", 64'(ms_to_ws_valid), 64'd1);
    chk("lh_stall_allowin0", 64'(ms_allowin), 64'd0);
    cyc();
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'hDEAD_BEEF;
    #1;
    chk("lh_buf_allowin", 64'(ms_allowin), 64'd0);
    chk("lh_buf_valid", 64'(ms_to_ws_valid), 64'd1);
    chk("lh_buf_result", 64'(ms_final_result), 64'h0000_80FF);
    cyc();
    ws_allowin = 1'b1;
    #1;
    chk("lh_drain_allowin", 64'(ms_allowin), 64'd1);
    cyc();

    // flush in WAIT; following ALU op must not take the stale response
    offer(32'h10C, 5'd6, 32'h0000_3000, 1'b1, 1'b1, LD_W, 1'b0);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    #1;
    chk("flush_cnt_one", 64'(dut.discard_cnt), 64'd1);
    chk("flush_empty", 64'(ms_to_ws_valid), 64'd0);
    sb.push_back('{pc: 32'h110, dest: 5'd7, res: 32'hCAFE_0001});
    offer(32'h110, 5'd7, 32'hCAFE_0001, 1'b0, 1'b0, LD_W, 1'b0);
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h1111_1111;
    cyc();
    data_sram_data_ok = 1'b0;
    #1;
    chk("discard_cnt_zero", 64'(dut.discard_cnt), 64'd0);

    // flush coincident with the response: counter stays clear
    offer(32'h114, 5'd8, 32'h0000_4000, 1'b1, 1'b1, LD_W, 1'b0);
    flush = 1'b1;
    ws_allowin = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h2222_2222;
    cyc();
    flush = 1'b0;
    ws_allowin = 1'b1;
    data_sram_data_ok = 1'b0;
    #1;
    chk("coinc_cnt_zero", 64'(dut.discard_cnt), 64'd0);
    chk("coinc_empty", 64'(ms_to_ws_valid), 64'd0);
    sb.push_back('{pc: 32'h118, dest: 5'd9, res: 32'hFFFF_8001});
    offer(32'h118, 5'd9, 32'h0000_4000, 1'b1, 1'b1, LD_H, 1'b0);
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h1234_8001;
    #1;
    chk("coinc_next_valid", 64'(ms_to_ws_valid), 64'd1);
    cyc();
    data_sram_data_ok = 1'b0;

    // back-to-back ALU ops: accept while the previous one leaves
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{pc: 32'h200 + 32'(i * 4), dest: 5'(10 + i), res: 32'hA000_0000 + 32'(i)});
      offer(32'h200 + 32'(i * 4), 5'(10 + i), 32'hA000_0000 + 32'(i), 1'b0, 1'b0, LD_W, 1'b0);
    end
    cyc();

    // asynchronous reset while a load waits with a pending discard
    offer(32'h300, 5'd20, 32'h0000_5000, 1'b1, 1'b1, LD_W, 1'b0);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    offer(32'h304, 5'd21, 32'h0000_5004, 1'b1, 1'b1, LD_W, 1'b0);
    chk("pre_rst_block", 64'(ms_fwd_block), 64'd1);
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_allowin", 64'(ms_allowin), 64'd1);
    chk("arst_valid", 64'(ms_to_ws_valid), 64'd0);
    chk("arst_pc", 64'(ms_pc), 64'd0);
    chk("arst_dest", 64'(ms_dest), 64'd0);
    chk("arst_result", 64'(ms_final_result), 64'd0);
    chk("arst_fwd", 64'({ms_fwd_valid, ms_fwd_block, ms_gr_we}), 64'd0);
    chk("arst_cnt", 64'(dut.discard_cnt), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    cyc();

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_stage_pipe.md
# mem_stage_pipe

Parametrised memory-access pipeline stage between the execute stage and the write-back stage. It holds one instruction and, for loads, waits for the split-transaction data-SRAM response (`data_ok`). It buffers that response when write-back stalls and extracts and sign- or zero-extends sub-word load data. It drops the responses of flushed loads and drives a forwarding/blocking port for the decode-stage hazard unit.

## Interface
Parameters:
- `XLEN`, 32 — datapath width; 32 or 64.
- `REG_AW`, 5 — register-index width.
- `MAX_OUTSTANDING`, 2 — maximum number of flushed-but-unanswered data requests the stage must absorb.

Ports:
- `clk`  in  1  — clock; all state updates on rising edge.
- `resetn`  in  1  — asynchronous, active-low reset.
- `flush`  in  1  — cancel stage contents (exception/return).
- `es_to_ms_valid`  in  1  — execute stage offers an instruction.
- `ms_allowin`  out  1  — stage accepts this cycle.
- `es_pc`  in  XLEN — instruction PC.
- `es_gr_we`  in  1 — register write enable.
- `es_dest`  in  REG_AW — destination register.
- `es_alu_result`  in  XLEN — ALU result / effective address.
- `es_res_from_mem`  in  1 — result comes from load data.
- `es_mem_req`  in  1 — a data request was accepted for this instruction; a `data_ok` will follow.
- `es_ld_size`  in  2 — 0 byte, 1 half, 2 word, 3 dword (XLEN=64 only).
- `es_ld_unsigned`  in  1 — zero-extend when 1, sign-extend when 0.
- `data_sram_data_ok`  in  1 — response strobe; responses return in request order.
- `data_sram_rdata`  in  XLEN — response data, valid with `data_ok`.
- `ms_to_ws_valid`  out  1 — result offered to write-back.
- `ws_allowin`  in  1 — write-back accepts.
- `ms_pc`, `ms_gr_we`, `ms_dest`, `ms_final_result`  out — payload to write-back.
- `ms_fwd_valid`  out  1 — `ms_final_result` is forwardable this cycle.
- `ms_fwd_block`  out  1 — a pending load targets `ms_dest`; the consumer must stall.

## Operation
- FSM states:
  - EMPTY: no instruction.
  - WAIT: load accepted, `data_ok` not yet seen.
  - READY: result available, either ALU result or buffered load data.
- Accept: on `es_to_ms_valid && ms_allowin && !flush`, latch payload. Next state is WAIT if `es_mem_req`, else READY.
- WAIT with `data_ok` and `discard_cnt == 0`:
  - if `ws_allowin`, pass the extracted data straight through and leave the stage (ready_go = 1 the same cycle);
  - otherwise store the raw rdata in a buffer and go to READY.
- `ms_allowin = !ms_valid || (ready_go && ws_allowin)`. Here `ready_go = (state==READY) || (state==WAIT && data_ok && discard_cnt==0)`.
- Load extraction:
  - offset = `alu_result[log2(XLEN/8)-1:0]`;
  - select the byte/half/word lane at offset × 8;
  - extend to XLEN per `ld_unsigned`;
  - size = XLEN passes unchanged.
  - Misaligned offsets are excluded upstream; the result is don't-care.
- `ms_final_result` = extracted load data if `res_from_mem`, else `alu_result`.
- Flush:
  - `ms_valid` clears next edge and the incoming instruction is dropped.
  - If state is WAIT and no `data_ok` arrives this cycle, `discard_cnt` increments.
- Discard: while `discard_cnt > 0`, each `data_ok` decrements it and is ignored. New instructions may enter meanwhile; in-order return guarantees correct matching.
- If flush and `data_ok` coincide in WAIT, that response belongs to the flushed load: it is consumed and the counter is unchanged.
- `discard_cnt` width is `$clog2(MAX_OUTSTANDING+1)`. Upstream never exceeds `MAX_OUTSTANDING`; the counter saturates (assertion in sim).
- `ms_fwd_valid = ms_valid && ms_gr_we && ready_go`.
- `ms_fwd_block = ms_valid && ms_gr_we && res_from_mem && !ready_go`.

## Timing
- Reset (asynchronous, `resetn=0`):
  - state EMPTY, `discard_cnt=0`, buffer and payload 0;
  - all outputs 0 except `ms_allowin=1`.
- Non-load latency: 1 cycle (accept edge → `ms_to_ws_valid` high next cycle).
- Load latency: `data_ok` cycle; `ms_to_ws_valid` is combinational from `data_ok`.
- `ms_to_ws_valid` stays asserted with a stable payload until `ws_allowin`.
- Flush takes effect at the next edge and wins over a simultaneous accept.
- Reset mid-WAIT clears `discard_cnt`. The memory side is reset together, so there are no stale responses.

## Structure
- Shared package `mycpu_pkg`: load-size encodings (`LD_B/LD_H/LD_W/LD_D`) and FSM state enum.
- One sub-module `load_align #(XLEN)`: combinational lane select plus extension.
- Stage FSM, payload registers, response buffer and discard counter live in `mem_stage_pipe`.

## Test plan
- ALU op with `alu_result=0x1234_5678` and `ws_allowin=1` → `ms_to_ws_valid` one cycle later, `ms_final_result=0x1234_5678`.
- Byte load, offset 3, signed, `rdata=0x80FF_FF00`, `data_ok` 3 cycles later → result `0xFFFF_FF80` in the `data_ok` cycle; `ms_fwd_block=1` during the wait.
- Half load, offset 2, unsigned, `data_ok` while `ws_allowin=0` for 2 cycles → buffered; then result `0x0000_80FF`, and `ms_allowin` stays low until drained.
- Flush in WAIT, new ALU op enters, then `data_ok` arrives → response discarded; ALU op retires with its own result; `discard_cnt` returns to 0.
- Flush coincident with `data_ok` → counter stays 0; the next load's `data_ok` is consumed normally.
- Assert `resetn` low mid-WAIT → all outputs 0 and `ms_allowin=1` immediately, without waiting for a clock edge.
